// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline slice with fully registered forward and backward paths.
// The skid entry absorbs the single beat accepted while back-pressure propagates upstream.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic [1:0]       level_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             m_valid_q;
    logic             s_ready_q;
    logic [1:0]       level_q;

    logic in_xfer;
    logic out_xfer;

    // Handshakes use only registered outputs, so no input reaches an output combinationally.
    assign in_xfer  = s_valid_i & s_ready_q;
    assign out_xfer = m_valid_q & m_ready_i;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            level_q   <= 2'd0;
        end else begin
            case (state_q)
                EMPTY: begin
                    // Ready rises on the first edge out of reset even without traffic.
                    s_ready_q <= 1'b1;
                    if (in_xfer) begin
                        main_q    <= s_data_i;
                        state_q   <= BUSY;
                        m_valid_q <= 1'b1;
                        level_q   <= 2'd1;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= s_data_i;
                    end else if (in_xfer) begin
                        skid_q    <= s_data_i;
                        state_q   <= FULL;
                        s_ready_q <= 1'b0;
                        level_q   <= 2'd2;
                    end else if (out_xfer) begin
                        state_q   <= EMPTY;
                        m_valid_q <= 1'b0;
                        level_q   <= 2'd0;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_q    <= skid_q;
                        state_q   <= BUSY;
                        s_ready_q <= 1'b1;
                        level_q   <= 2'd1;
                    end
                end
                default: begin
                    state_q   <= EMPTY;
                    m_valid_q <= 1'b0;
                    s_ready_q <= 1'b1;
                    level_q   <= 2'd0;
                end
            endcase
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = main_q;
    assign level_o   = level_q;

    // A presented beat must stay put until the consumer takes it.
    property p_out_stable;
        @(posedge clk) disable iff (!rstn)
            (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o));
    endproperty
    a_out_stable: assert property (p_out_stable);

endmodule

// File: tb/tb_skid_buffer.sv
// Randomized and directed traffic through skid_buffer, checked by a queue-based scoreboard
// whose occupancy also predicts level, m_valid and s_ready.
module tb_skid_buffer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] level;

    int vectors = 0;
    int miscompares = 0;
    int beats_out = 0;

    logic [7:0] sb_q[$];
    bit started = 1'b0;
    bit armed = 1'b0;
    bit last_in = 1'b0;

    always #5 clk = ~clk;

    skid_buffer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_data_i (s_data),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_data_o (m_data),
        .level_o  (level)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model of what the last rising edge did: a low reset empties the buffer.
    always @(posedge clk) begin
        started = 1'b1;
        if (!rstn) begin
            sb_q.delete();
            armed = 1'b0;
        end else begin
            armed = 1'b1;
        end
    end

    // Monitor: inputs are driven just after the rising edge, so mid-cycle everything is settled.
    always @(negedge clk) begin
        if (started) begin
            chk("level", int'(level), sb_q.size());
            chk("m_valid", int'(m_valid), (sb_q.size() != 0) ? 1 : 0);
            chk("s_ready", int'(s_ready), (armed && sb_q.size() < 2) ? 1 : 0);
            if (!armed)
                chk("reset_m_data", int'(m_data), 0);
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", int'(m_data), -1);
                end else begin
                    logic [7:0] exp_d;
                    exp_d = sb_q.pop_front();
                    beats_out++;
                    $display("beat %0d out: data 0x%02h expected 0x%02h", beats_out, m_data, exp_d);
                    chk("m_data", int'(m_data), int'(exp_d));
                end
            end
            last_in = s_valid && s_ready;
            if (last_in)
                sb_q.push_back(s_data);
        end
    end

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for three edges, then released.
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", int'(s_ready), 0);
        @(negedge clk);
        chk("ready_after_release", int'(s_ready), 1);
        @(posedge clk);
        #1;

        // Streaming 0x01..0x10 back to back.
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++)
            send(8'(i));
        idle(3);

        // Stall into FULL, then release.
        send(8'hA0);
        m_ready = 1'b0;
        send(8'hA1);
        @(negedge clk);
        chk("stall_level", int'(level), 2);
        chk("stall_main", int'(m_data), 8'hA0);
        chk("stall_ready", int'(s_ready), 0);
        @(posedge clk);
        #1;
        fork
            send(8'hA2);
            begin
                idle(3);
                m_ready = 1'b1;
            end
        join

        // Drain to empty with m_ready left high.
        idle(4);
        @(negedge clk);
        chk("drain_level", int'(level), 0);
        chk("drain_valid", int'(m_valid), 0);
        @(posedge clk);
        #1;

        // Fill with 0x55/0x66, reset for one edge, then 0x77 must be the first beat out.
        m_ready = 1'b0;
        send(8'h55);
        send(8'h66);
        @(negedge clk);
        chk("full_level", int'(level), 2);
        chk("full_main", int'(m_data), 8'h55);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("midreset_level", int'(level), 0);
        chk("midreset_valid", int'(m_valid), 0);
        chk("midreset_data", int'(m_data), 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(8'h77);
        @(negedge clk);
        chk("after_reset_first", int'(m_data), 8'h77);
        chk("after_reset_valid", int'(m_valid), 1);
        idle(2);

        // Random traffic; the producer holds a pending beat until it is accepted.
        for (int c = 0; c < 10000; c++) begin
            if (!s_valid || last_in) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 8'($urandom);
            end
            m_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        idle(6);
        chk("final_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
